alu_mul_sequencer: RTL
======================

Name: alu_mul_sequencer

Overview:
Multi-cycle shift-and-add multiplier controller that borrows the shared 32-bit ALU for its additions. It requests the ALU from the main control FSM through a req/gnt handshake and drives SrcA/SrcB/ALUControl while it holds the grant. It keeps its own shift registers and iteration counter, and returns the low 32 bits of the product. It sits beside the main multi-cycle controller and serves M-extension MUL.

Parameters:
XLEN, 32, operand/product width; must equal the ALU width (32).
EARLY_EXIT, 1, 1 = terminate once the remaining multiplier bits are all zero; 0 = always iterate XLEN bits.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a multiply; sampled only in IDLE
op_a  in  XLEN  multiplicand, latched on accepted start
op_b  in  XLEN  multiplier, latched on accepted start
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse in the DONE state
product  out  XLEN  low XLEN bits of op_a*op_b; valid at done and held until the next accepted start
alu_req  out  1  ALU request; high only in ADD
alu_gnt  in  1  ALU granted this cycle
alu_srca  out  XLEN  drives ALU SrcA
alu_srcb  out  XLEN  drives ALU SrcB
alu_ctrl  out  3  drives ALUControl; always 3'b000 (add)
alu_result  in  XLEN  ALU result

Behaviour:
- Reset: synchronous, active-high, one clock. All state goes to IDLE. busy=0, done=0, product=0, alu_req=0, alu_srca=0, alu_srcb=0, alu_ctrl=000. Internal acc, mcand, mplier and cnt are cleared. Reset mid-operation abandons the operation with no done pulse.
- Internal state: acc, mcand, mplier (XLEN bits each); cnt (5 bits).
- IDLE:
  - start=1 → acc=0, mcand=op_a, mplier=op_b, cnt=0; go to CHECK.
  - start is ignored in every other state.
- CHECK:
  - mplier[0]=1 → go to ADD.
  - Otherwise perform the step, then exit-test.
- ADD:
  - Outputs: alu_req=1, alu_srca=acc, alu_srcb=mcand, alu_ctrl=000.
  - These outputs are held stable while alu_gnt=0.
  - On alu_gnt=1: acc<=alu_result, perform the step, then exit-test.
- Step: mcand<=mcand<<1 (bits shifted out are dropped), mplier<=mplier>>1, cnt<=cnt+1.
- Exit-test:
  - If cnt==XLEN-1, or (EARLY_EXIT and (mplier>>1)==0), go to DONE.
  - Otherwise go to CHECK.
- DONE: done=1, product<=final acc (visible the same cycle), busy=1; go to IDLE next cycle.
- ALU outputs outside ADD: req=0, srca=0, srcb=0, ctrl=000.
- Latency: start edge → done = (bits processed) + (set bits processed) + (grant stall cycles) + 1.
- Arithmetic wraps modulo 2^XLEN. Signed and unsigned MUL give identical low halves, so there is no sign handling.
- alu_gnt asserted outside ADD is ignored.
- start asserted in DONE is ignored. The earliest accepted restart is the IDLE cycle after DONE.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds output perf_cycles [15:0], the cycles from the accepted start edge to done inclusive.
- Defined: adds output perf_stalls [15:0], the cycles spent in ADD with alu_gnt=0.
- Both outputs update in the DONE cycle, are held otherwise, reset to 0, and saturate at 16'hFFFF.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- 3*5, alu_gnt=1, EARLY_EXIT=1 → done in cycle 6 after the start edge, product=15. Exactly two ALU requests: (srca 0, srcb 3), then (srca 3, srcb 12). perf_cycles=6.
- op_a=9, op_b=0 → done in cycle 2, product=0, alu_req never high.
- 32'hFFFFFFFF*32'hFFFFFFFF, gnt=1 → 32 ADD cycles, done in cycle 65, product=32'h00000001.
- 7*32'h80000000, EARLY_EXIT=0 → exactly one ADD (last bit), done in cycle 34, product=32'h80000000.
- 3*5 with alu_gnt=0 for the first 3 ADD cycles → srca/srcb/ctrl held constant, done in cycle 9, product=15, perf_stalls=3.
- start pulsed while busy → ignored, result unchanged. reset asserted mid-operation → next cycle busy=0, done=0, product=0, alu_req=0; a following start runs normally.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU for its additions.
// Optional `define ALU_SEQ_PERF_EN adds perf_cycles/perf_stalls counters.
module alu_mul_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]     perf_cycles,
  output logic [15:0]     perf_stalls
`endif
);

  localparam int unsigned CntW    = 5;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [2:0]  AluAdd  = 3'b000;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StAdd   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] product_q, product_d;
  logic            do_step;
  logic            accept;

  assign accept = (state_q == StIdle) && start;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    do_step   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (mplier_q[0]) begin
          state_d = StAdd;
        end else begin
          do_step = 1'b1;
        end
      end
      StAdd: begin
        // Request/operands stay put until the main controller grants the ALU.
        if (alu_gnt) begin
          acc_d   = alu_result;
          do_step = 1'b1;
        end
      end
      StDone: begin
        product_d = acc_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (do_step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if ((cnt_q == CntLast) || ((EARLY_EXIT != 0) && (mplier_d == '0))) begin
        state_d = StDone;
      end else begin
        state_d = StCheck;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    // Final accumulator is visible in the DONE cycle itself, then held in product_q.
    product  = done ? acc_q : product_q;
    alu_req  = (state_q == StAdd);
    alu_srca = alu_req ? acc_q : '0;
    alu_srcb = alu_req ? mcand_q : '0;
    alu_ctrl = AluAdd;
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    cyc_d         = cyc_q;
    stall_d       = stall_q;
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    // cyc_q equals the number of cycles since the accepted start edge.
    if (accept) begin
      cyc_d   = 16'd1;
      stall_d = '0;
    end else if ((state_q == StCheck) || (state_q == StAdd)) begin
      if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
      if ((state_q == StAdd) && !alu_gnt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end
    if (state_q == StDone) begin
      perf_cycles_d = cyc_q;
      perf_stalls_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q         <= '0;
      stall_q       <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      cyc_q         <= cyc_d;
      stall_q       <= stall_d;
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = (state_q == StDone) ? cyc_q : perf_cycles_q;
  assign perf_stalls = (state_q == StDone) ? stall_q : perf_stalls_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
